// File: rtl/mext_unit_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package mext_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mulop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mext_state_t;

    // rs1 is treated as signed by every op except the fully unsigned ones
    function automatic logic signed_a(input mulop_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic signed_b(input mulop_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_div(input mulop_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/mext_unit_if.sv
// EX-stage <-> M-extension unit handshake and operand bus.
interface mext_unit_if;
    import mext_unit_pkg::*;

    logic              enable;
    mulop_t            mulop;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic              hold;
    logic [XLEN-1:0]   out;
    logic              pause;

    modport master (output enable, mulop, rs1, rs2, hold, input out, pause);
    modport slave  (input enable, mulop, rs1, rs2, hold, output out, pause);

endinterface

// File: rtl/mext_divider.sv
// Restoring radix-2 divider step on unsigned magnitudes; one quotient bit per step.
module mext_divider
    import mext_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next_c,
    output logic [XLEN-1:0] rem_next_c
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   trial;

    // rem_q < divisor always holds, so bit XLEN of the trial is the borrow
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        if (!trial[XLEN]) begin
            rem_next_c = trial[XLEN-1:0];
            quo_next_c = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next_c = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_next_c = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            quo_q <= quo_next_c;
            rem_q <= rem_next_c;
        end
    end

endmodule

// File: rtl/mext_unit.sv
// Multi-cycle RV32M multiply/divide unit for EX: stalls via pause, result on out.
module mext_unit
    import mext_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mext_unit_if.slave bus
);

    mext_state_t      state_q, state_d;
    mulop_t           op_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  mcand_q;
    logic [PW-1:0]    prod_q;
    logic [XLEN-1:0]  out_q;

    logic             start, step, finish;
    logic             sa, sb, special, neg_start;
    logic [XLEN-1:0]  mag_a, mag_b, special_res;
    logic [XLEN:0]    sum;
    logic [PW-1:0]    prod_next, prod_fix;
    logic [XLEN-1:0]  quo_next, rem_next, res_c;

    // Operand decode on the live bus, used only on the start cycle
    always_comb begin
        sa          = signed_a(bus.mulop) & bus.rs1[XLEN-1];
        sb          = signed_b(bus.mulop) & bus.rs2[XLEN-1];
        mag_a       = sa ? -bus.rs1 : bus.rs1;
        mag_b       = sb ? -bus.rs2 : bus.rs2;
        special     = 1'b0;
        special_res = '0;
        if (is_div(bus.mulop)) begin
            if (bus.rs2 == '0) begin
                special     = 1'b1;
                special_res = ((bus.mulop == DIV) || (bus.mulop == DIVU)) ? '1 : bus.rs1;
            end else if (((bus.mulop == DIV) || (bus.mulop == REM)) &&
                         (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1)) begin
                special     = 1'b1;
                special_res = (bus.mulop == DIV) ? bus.rs1 : '0;
            end
        end
        // Remainder follows the dividend sign; product and quotient follow sign difference
        neg_start = (bus.mulop == REM) ? sa : (sa ^ sb);
    end

    // Shift-add multiply step: accumulate into the high half, shift right
    always_comb begin
        sum       = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_next = {sum, prod_q[XLEN-1:1]};
        prod_fix  = neg_q ? -prod_next : prod_next;
    end

    always_comb begin
        res_c = '0;
        unique case (op_q)
            MUL:                 res_c = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: res_c = prod_fix[PW-1:XLEN];
            DIV, DIVU:           res_c = neg_q ? -quo_next : quo_next;
            REM, REMU:           res_c = neg_q ? -rem_next : rem_next;
        endcase
    end

    mext_divider u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (start),
        .step       (step),
        .dividend   (mag_a),
        .divisor    (mag_b),
        .quo_next_c (quo_next),
        .rem_next_c (rem_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    start   = 1'b1;
                    state_d = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MUL;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            out_q   <= '0;
        end else begin
            if (start) begin
                op_q    <= bus.mulop;
                neg_q   <= neg_start;
                cnt_q   <= '0;
                mcand_q <= mag_a;
                prod_q  <= {{XLEN{1'b0}}, mag_b};
                if (special) out_q <= special_res;
            end
            if (step) begin
                prod_q <= prod_next;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (finish) out_q <= res_c;
        end
    end

    assign bus.pause = bus.enable & (state_q != DONE) & ~rst;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_mext_unit.sv
// Directed self-checking bench for mext_unit: vector table plus control-event sequences.
module tb_mext_unit;
    import mext_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    mext_unit_if bus ();

    mext_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        mulop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an op and count edges until pause drops; bounded at 100 cycles.
    task automatic issue(input mulop_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit from_done, output int lat);
        bus.mulop  = op;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.enable = 1'b1;
        if (from_done) @(posedge clk);
        #1;
        lat = 0;
        while (bus.pause && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                bus.mulop = mulop_t'($urandom_range(0, 7));
                bus.rs1   = $urandom;
                bus.rs2   = $urandom;
            end
        end
    endtask

    task automatic release_op;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.hold   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] last_exp;

        vecs[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[4]  = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        vecs[5]  = '{MULHU,  32'h80000000, 32'd4,        32'h00000002, 33};
        vecs[6]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[7]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[8]  = '{DIVU,   32'd100,      32'd7,        32'd14,       33};
        vecs[9]  = '{REMU,   32'd100,      32'd7,        32'd2,        33};
        vecs[10] = '{DIV,    32'd1234,     32'd0,        32'hFFFFFFFF, 1};
        vecs[11] = '{DIVU,   32'd1234,     32'd0,        32'hFFFFFFFF, 1};
        vecs[12] = '{REMU,   32'd5,        32'd0,        32'd5,        1};
        vecs[13] = '{REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
        vecs[14] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[15] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[16] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[17] = '{REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

        bus.enable = 1'b1;
        bus.hold   = 1'b0;
        bus.mulop  = MUL;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pause", {31'd0, bus.pause}, 32'd0);
        check("reset_out", bus.out, 32'd0);
        bus.enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_pause", {31'd0, bus.pause}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_out", i), bus.out, vecs[i].exp);
            release_op();
        end
        last_exp = vecs[NV-1].exp;

        // Abort in BUSY: pause drops at once, out untouched, clean restart after
        bus.mulop  = MUL;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        bus.enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_pause", {31'd0, bus.pause}, 32'd1);
        #1;
        bus.enable = 1'b0;
        #1;
        check("abort_pause_drop", {31'd0, bus.pause}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_out_kept", bus.out, last_exp);
        @(negedge clk);
        issue(MUL, 32'd3, 32'd5, 1'b0, lat);
        check("after_abort_latency", 32'(lat), 32'd33);
        check("after_abort_out", bus.out, 32'd15);
        release_op();

        // Hold in DONE: out stable, no restart while enable stays high
        bus.hold = 1'b1;
        issue(DIVU, 32'd100, 32'd7, 1'b0, lat);
        check("hold_latency", 32'(lat), 32'd33);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_out", k), bus.out, 32'd14);
            check($sformatf("hold%0d_pause", k), {31'd0, bus.pause}, 32'd0);
        end
        release_op();

        // Back-to-back: new op presented during DONE, enable never drops
        issue(MUL, 32'd6, 32'd7, 1'b0, lat);
        check("b2b_mul_latency", 32'(lat), 32'd33);
        check("b2b_mul_out", bus.out, 32'd42);
        @(negedge clk);
        issue(DIVU, 32'd1000, 32'd10, 1'b1, lat);
        check("b2b_divu_latency", 32'(lat), 32'd33);
        check("b2b_divu_out", bus.out, 32'd100);
        release_op();

        // Asynchronous reset between edges in BUSY
        bus.mulop  = MUL;
        bus.rs1    = 32'd7;
        bus.rs2    = 32'hFFFFFFFD;
        bus.enable = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_pause", {31'd0, bus.pause}, 32'd0);
        check("rst_mid_out", bus.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        issue(REM, 32'hFFFFFFF9, 32'd2, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_out", bus.out, 32'hFFFFFFFF);
        release_op();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
